// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the five-operand carry-save adder pipeline.
// The stage-1 vector bundle is a macro because its width follows the instantiating module's W.
`define CSA_VEC_T(WIDTH) struct packed { logic [(WIDTH)-1:0] s; logic [(WIDTH)-1:0] c; logic [(WIDTH)-1:0] co; }

package csa_pkg;

    localparam int unsigned CNT_W = 16;

    // Sum of five W-bit operands needs at most 3 extra bits: 5*(2^W-1) < 2^(W+3).
    function automatic int unsigned sum_w(input int unsigned w);
        return w + 3;
    endfunction

endpackage

// File: rtl/csa_sum5_pipe_if.sv
// Operand-in / sum-out valid-ready bundle for csa_sum5_pipe.
import csa_pkg::*;

interface csa_sum5_pipe_if #(
    parameter int unsigned W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            in_a;
    logic [W-1:0]            in_b;
    logic [W-1:0]            in_c;
    logic [W-1:0]            in_d;
    logic [W-1:0]            in_e;
    logic                    out_valid;
    logic                    out_ready;
    logic [sum_w(W)-1:0]     out_sum;
    logic [CNT_W-1:0]        out_cnt;

    // Environment side: drives operands and consumes sums.
    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_e, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt
    );

    // Adder side.
    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_e, out_ready,
        output in_ready, out_valid, out_sum, out_cnt
    );
endinterface

// File: rtl/csa_sum5_pipe_counter.sv
// Existing 5:3 counter cell: x[1]+x[2]+x[3]+x[4]+c_in = s + 2*c + 4*c_out.
module counter_5_to_3 (
    input  logic [4:1] x,
    input  logic       c_in,
    output logic       s,
    output logic       c,
    output logic       c_out
);
    logic s1, c1, c2;

    // Two full adders; their two weight-2 carries are then half-added.
    assign s1    = x[1] ^ x[2] ^ x[3];
    assign c1    = (x[1] & x[2]) | (x[1] & x[3]) | (x[2] & x[3]);
    assign s     = s1 ^ x[4] ^ c_in;
    assign c2    = (s1 & x[4]) | (s1 & c_in) | (x[4] & c_in);
    assign c     = c1 ^ c2;
    assign c_out = c1 & c2;
endmodule

// File: rtl/csa_sum5_pipe.sv
// Two-stage streaming adder of five W-bit unsigned operands: carry-save compression
// into S/C/CO, then a registered carry-propagate add, with valid/ready flow control.
module csa_sum5_pipe
    import csa_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 aresetn,
    csa_sum5_pipe_if.slave       bus
);
    localparam int unsigned SW = sum_w(W);

    typedef `CSA_VEC_T(W) csa_vec_t;

    logic [W-1:0]     col_s, col_c, col_co;
    csa_vec_t         col_d;
    csa_vec_t         st1_q;
    logic             v1_q;
    logic             out_valid_q;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             adv1, adv2;

    for (genvar i = 0; i < W; i++) begin : g_col
        counter_5_to_3 u_cnt (
            .x     ({bus.in_d[i], bus.in_c[i], bus.in_b[i], bus.in_a[i]}),
            .c_in  (bus.in_e[i]),
            .s     (col_s[i]),
            .c     (col_c[i]),
            .c_out (col_co[i])
        );
    end

    always_comb begin
        col_d    = '0;
        col_d.s  = col_s;
        col_d.c  = col_c;
        col_d.co = col_co;
    end

    always_comb begin
        sum_d = SW'(st1_q.s) + (SW'(st1_q.c) << 1) + (SW'(st1_q.co) << 2);
    end

    // Stage 2 advances when it is empty or being drained; stage 1 whenever it is empty or moves on.
    always_comb begin
        adv2 = v1_q & (~out_valid_q | bus.out_ready);
        adv1 = ~v1_q | adv2;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v1_q  <= 1'b0;
            st1_q <= '0;
        end else if (adv1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                st1_q <= col_d;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else if (~out_valid_q | bus.out_ready) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                sum_q <= sum_d;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (out_valid_q & bus.out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cnt   = cnt_q;
endmodule

// File: tb/tb_csa_sum5_pipe.sv
// Randomised bench for csa_sum5_pipe: reference sums come from plain integer addition.
module tb_csa_sum5_pipe;
    import csa_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic aresetn;

    always #5 clk = ~clk;

    csa_sum5_pipe_if #(.W(W)) bif ();

    csa_sum5_pipe #(.W(W)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bif.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int got_q[$];

    // One cycle, entered and left at a falling edge: drive, settle, record transfers, clock.
    task automatic step(input bit v, input bit r,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] d, input logic [W-1:0] e,
                        output bit acc, output bit rdy);
        bif.in_valid  = v;
        bif.out_ready = r;
        bif.in_a = a; bif.in_b = b; bif.in_c = c; bif.in_d = d; bif.in_e = e;
        #1;
        rdy = bif.in_ready;
        acc = v && rdy;
        if (acc) exp_q.push_back(int'(a) + int'(b) + int'(c) + int'(d) + int'(e));
        if (bif.out_valid && r) got_q.push_back(int'(bif.out_sum));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_step(output bit acc);
        bit rdy;
        step(1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), acc, rdy);
    endtask

    task automatic drain(output bit ok);
        bit acc, rdy;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (got_q.size() == exp_q.size() && !bif.out_valid) begin
                ok = 1'b1;
                break;
            end
            step(1'b0, 1'b1, '0, '0, '0, '0, '0, acc, rdy);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        bif.in_valid = 1'b0; bif.out_ready = 1'b0;
        bif.in_a = '0; bif.in_b = '0; bif.in_c = '0; bif.in_d = '0; bif.in_e = '0;
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bif.out_valid); end
        checks++;
        if (bif.out_cnt !== 16'd0) begin errors++; $display("FAIL reset_out_cnt got %0d want 0", bif.out_cnt); end
        checks++;
        if (bif.out_sum !== 11'd0) begin errors++; $display("FAIL reset_out_sum got %0d want 0", bif.out_sum); end
        aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bif.in_ready); end
        checks++;
        if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b want 0", bif.out_valid); end
    endtask

    task automatic test_column();
        bit acc, rdy, ok;
        logic [4:0] v;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            step(1'b1, 1'b1, W'(v[0]), W'(v[1]), W'(v[2]), W'(v[3]), W'(v[4]), acc, rdy);
        end
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 32) begin
            errors++; $display("FAIL column_count got %0d want 32", got_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (got_q[i] != $countones(i)) begin
                    errors++; $display("FAIL column_sum idx %0d got %0d want %0d", i, got_q[i], $countones(i));
                end
            end
        end
    endtask

    task automatic test_max();
        bit acc, rdy;
        exp_q.delete(); got_q.delete();
        step(1'b1, 1'b1, '1, '1, '1, '1, '1, acc, rdy);
        checks++;
        if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid got %b want 0", bif.out_valid); end
        step(1'b0, 1'b1, '0, '0, '0, '0, '0, acc, rdy);
        checks++;
        if (bif.out_valid !== 1'b1 || bif.out_sum !== 11'h4FB) begin
            errors++; $display("FAIL max_sum valid %b sum 0x%0h want valid 1 sum 0x4fb", bif.out_valid, bif.out_sum);
        end
        step(1'b0, 1'b1, '0, '0, '0, '0, '0, acc, rdy);
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back_stall();
        logic [W-1:0] ops[10][5];
        bit acc, rdy, r;
        int idx = 0;
        for (int i = 0; i < 10; i++) begin
            ops[i][0] = W'(i);
            for (int k = 1; k < 5; k++) ops[i][k] = W'($urandom);
        end
        exp_q.delete(); got_q.delete();
        for (int cyc = 0; cyc < 40 && got_q.size() < 10; cyc++) begin
            r = !(cyc >= 3 && cyc < 8);
            if (idx < 10) step(1'b1, r, ops[idx][0], ops[idx][1], ops[idx][2], ops[idx][3], ops[idx][4], acc, rdy);
            else          step(1'b0, r, '0, '0, '0, '0, '0, acc, rdy);
            if (acc) idx++;
            if (cyc == 5) begin
                checks++;
                if (rdy !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", rdy); end
                checks++;
                if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got %b want 1", bif.out_valid); end
            end
        end
        checks++;
        if (got_q.size() != 10 || exp_q.size() != 10) begin
            errors++; $display("FAIL stall_count got %0d want 10 (sent %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    errors++; $display("FAIL stall_sum idx %0d got %0d want %0d", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_throughput();
        bit acc, ok;
        int missed = 0;
        int bad = 0;
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            rand_step(acc);
            if (!acc) missed++;
        end
        checks++;
        if (missed != 0) begin errors++; $display("FAIL tput_accept missed %0d want 0", missed); end
        checks++;
        if (got_q.size() != 998) begin errors++; $display("FAIL tput_rate got %0d want 998", got_q.size()); end
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 1000) begin
            errors++; $display("FAIL tput_count got %0d want 1000", got_q.size());
        end else begin
            for (int i = 0; i < 1000; i++) if (got_q[i] != exp_q[i]) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL tput_data mismatches %0d want 0", bad); end
        end
        checks++;
        if (bif.out_cnt !== 16'd1000) begin errors++; $display("FAIL tput_out_cnt got %0d want 1000", bif.out_cnt); end
    endtask

    task automatic test_reset_midstream();
        bit acc, rdy;
        do_reset();
        step(1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), acc, rdy);
        step(1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), acc, rdy);
        checks++;
        if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", bif.out_valid); end
        bif.in_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        checks++;
        if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_drop got %b want 0", bif.out_valid); end
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        exp_q.delete(); got_q.delete();
        repeat (6) step(1'b0, 1'b1, '0, '0, '0, '0, '0, acc, rdy);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale got %0d sums want 0", got_q.size()); end
        checks++;
        if (bif.out_cnt !== 16'd0) begin errors++; $display("FAIL mid_out_cnt got %0d want 0", bif.out_cnt); end
    endtask

    task automatic test_wrap();
        bit acc, ok;
        int bad = 0;
        do_reset();
        for (int n = 0; n < 65535; n++) rand_step(acc);
        drain(ok);
        checks++;
        if (bif.out_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got 0x%0h want 0xffff", bif.out_cnt); end
        rand_step(acc);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 65536) begin
            errors++; $display("FAIL wrap_count got %0d want 65536", got_q.size());
        end else begin
            for (int i = 0; i < 65536; i++) if (got_q[i] != exp_q[i]) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL wrap_data mismatches %0d want 0", bad); end
        end
        checks++;
        if (bif.out_cnt !== 16'd0) begin errors++; $display("FAIL wrap_out_cnt got %0d want 0", bif.out_cnt); end
    endtask

    initial begin
        aresetn = 1'b0;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_column();
        test_max();
        test_back_to_back_stall();
        test_throughput();
        test_reset_midstream();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
